// File: rtl/router_ctrl_fsm.sv
// Packet-receive controller for the 1x3 router: decodes the header destination,
// sequences header/payload/parity loading and stalls the source when needed.
module router_ctrl_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_DA  = 3'd0,
    S_LFD = 3'd1,
    S_LD  = 3'd2,
    S_FFS = 3'd3,
    S_LAF = 3'd4,
    S_LP  = 3'd5,
    S_CPE = 3'd6,
    S_WTE = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  // Address 2'b11 has no destination, so its flag reads as 0.
  function automatic logic dest_bit(input logic [2:0] vec, input logic [1:0] idx);
    case (idx)
      2'd0:    dest_bit = vec[0];
      2'd1:    dest_bit = vec[1];
      2'd2:    dest_bit = vec[2];
      default: dest_bit = 1'b0;
    endcase
  endfunction

  logic addr_ok;
  assign addr_ok = (data_in != 2'b11);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_DA: begin
        if (pkt_valid && addr_ok) begin
          addr_d  = data_in;
          state_d = dest_bit(fifo_empty, data_in) ? S_LFD : S_WTE;
        end
      end
      S_LFD: state_d = S_LD;
      S_LD: begin
        if (fifo_full)       state_d = S_FFS;
        else if (!pkt_valid) state_d = S_LP;
      end
      S_FFS: begin
        if (!fifo_full) state_d = S_LAF;
      end
      S_LAF: begin
        if (parity_done)        state_d = S_DA;
        else if (low_pkt_valid) state_d = S_LP;
        else                    state_d = S_LD;
      end
      S_LP:  state_d = S_CPE;
      S_CPE: state_d = fifo_full ? S_FFS : S_DA;
      S_WTE: begin
        if (dest_bit(fifo_empty, addr_q)) state_d = S_LFD;
      end
      default: state_d = S_DA;
    endcase

    // A soft reset of the selected destination abandons the packet from any busy state.
    if (state_q != S_DA && dest_bit(soft_reset, addr_q)) state_d = S_DA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_DA;
      addr_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign detect_add    = (state_q == S_DA);
  assign lfd_state     = (state_q == S_LFD);
  assign ld_state      = (state_q == S_LD);
  assign laf_state     = (state_q == S_LAF);
  assign full_state    = (state_q == S_FFS);
  assign rst_int_reg   = (state_q == S_CPE);
  assign write_enb_reg = (state_q == S_LD) || (state_q == S_LP) || (state_q == S_LAF);
  assign busy          = (state_q != S_DA) && (state_q != S_LD);

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm; each state is identified by the full
// output vector {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy}.
module tb_router_ctrl_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int ri_cnt = 0;

  localparam logic [7:0] E_DA  = 8'b1000_0000;
  localparam logic [7:0] E_LFD = 8'b0100_0001;
  localparam logic [7:0] E_LD  = 8'b0010_0100;
  localparam logic [7:0] E_LAF = 8'b0001_0101;
  localparam logic [7:0] E_FFS = 8'b0000_1001;
  localparam logic [7:0] E_LP  = 8'b0000_0101;
  localparam logic [7:0] E_CPE = 8'b0000_0011;
  localparam logic [7:0] E_WTE = 8'b0000_0001;

  router_ctrl_fsm dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  wire [7:0] outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                     write_enb_reg, rst_int_reg, busy};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later, tallying write/clear pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (write_enb_reg) we_cnt++;
    if (rst_int_reg)   ri_cnt++;
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs, E_DA);
    check("reset_addr", {6'd0, dut.addr_q}, 8'd0);
    resetn = 1'b1;

    // Normal packet, addr 1, 14 payload bytes.
    pkt_valid = 1'b1; data_in = 2'd1;
    we_cnt = 0; ri_cnt = 0;
    step(); check("norm_lfd", outs, E_LFD);
    for (int i = 1; i <= 14; i++) begin
      step(); check($sformatf("norm_ld%0d", i), outs, E_LD);
      if (i == 14) pkt_valid = 1'b0;
    end
    step(); check("norm_lp", outs, E_LP);
    step(); check("norm_cpe", outs, E_CPE);
    step(); check("norm_da", outs, E_DA);
    check("norm_we_cycles", we_cnt[7:0], 8'd15);
    check("norm_rst_int_cycles", ri_cnt[7:0], 8'd1);
    check("norm_addr", {6'd0, dut.addr_q}, 8'd1);

    // Busy destination 2 -> WTE; unrelated empty flag toggles are ignored.
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    step(); check("wte_enter", outs, E_WTE);
    fifo_empty = 3'b010;
    step(); check("wte_hold_a", outs, E_WTE);
    fifo_empty = 3'b011;
    step(); check("wte_hold_b", outs, E_WTE);
    fifo_empty = 3'b111;
    step(); check("wte_lfd", outs, E_LFD);
    fifo_full = 1'b1;                        // ignored while in LFD
    step(); check("lfd_ignores_full", outs, E_LD);
    fifo_full = 1'b0; pkt_valid = 1'b0;
    step(); check("wte_lp", outs, E_LP);
    step(); check("wte_cpe", outs, E_CPE);
    step(); check("wte_da", outs, E_DA);

    // FIFO full on addr 0 in the 5th LD cycle.
    pkt_valid = 1'b1; data_in = 2'd0;
    step(); check("full_lfd", outs, E_LFD);
    for (int i = 1; i <= 5; i++) begin
      step(); check($sformatf("full_ld%0d", i), outs, E_LD);
    end
    fifo_full = 1'b1;
    step(); check("full_ffs", outs, E_FFS);
    step(); check("full_ffs_hold", outs, E_FFS);
    fifo_full = 1'b0;
    step(); check("full_laf", outs, E_LAF);
    step(); check("laf_to_ld", outs, E_LD);
    fifo_full = 1'b1;
    step(); check("full_ffs2", outs, E_FFS);
    fifo_full = 1'b0;
    step(); check("full_laf2", outs, E_LAF);
    low_pkt_valid = 1'b1;
    step(); check("laf_to_lp", outs, E_LP);
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step(); check("full_cpe", outs, E_CPE);
    fifo_full = 1'b1;
    step(); check("cpe_to_ffs", outs, E_FFS);
    fifo_full = 1'b0;
    step(); check("full_laf3", outs, E_LAF);
    parity_done = 1'b1;
    step(); check("laf_to_da", outs, E_DA);
    parity_done = 1'b0;

    // Soft reset on addr 1; soft reset is ignored in DA and for other destinations.
    pkt_valid = 1'b1; data_in = 2'd1; soft_reset = 3'b010;
    step(); check("srst_ignored_in_da", outs, E_LFD);
    step(); check("srst_lfd_to_da", outs, E_DA);
    soft_reset = 3'b000;
    step(); check("srst_lfd", outs, E_LFD);
    step(); check("srst_ld", outs, E_LD);
    soft_reset = 3'b100;
    step(); check("srst_other_dest", outs, E_LD);
    soft_reset = 3'b010;
    step(); check("srst_ld_to_da", outs, E_DA);
    soft_reset = 3'b000;

    // Invalid address 3 is never accepted.
    data_in = 2'd3;
    for (int i = 1; i <= 3; i++) begin
      step(); check($sformatf("inval_da%0d", i), outs, E_DA);
    end
    check("inval_addr_held", {6'd0, dut.addr_q}, 8'd1);
    pkt_valid = 1'b0;

    // Asynchronous reset mid-LD, with no clock edge.
    pkt_valid = 1'b1; data_in = 2'd2;
    step(); check("ar_lfd", outs, E_LFD);
    step(); check("ar_ld", outs, E_LD);
    #2 resetn = 1'b0;
    #1 check("async_reset_outputs", outs, E_DA);
    check("async_reset_addr", {6'd0, dut.addr_q}, 8'd0);
    pkt_valid = 1'b0;
    #1 resetn = 1'b1;
    step(); check("post_reset_da", outs, E_DA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
Packet-receive controller for the 1x3 router. It decodes the 2-bit destination from the header byte and sequences header, payload and parity loading into the register stage and the three destination FIFOs. It stalls the source on FIFO-full and on destination-not-empty, and handles per-destination soft reset. It sits between the input port and the router register/FIFO datapath.

Parameters:
None. State encoding is internal; destination count is fixed at 3 and address 2'b11 is invalid.

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source asserts for header+payload bytes, deasserts with parity byte
data_in  input  2  header address bits [1:0], sampled in DECODE_ADDRESS
fifo_full  input  1  full flag of currently selected destination FIFO
fifo_empty  input  3  empty flags of FIFO 0..2
soft_reset  input  3  per-destination soft reset pulses from sync block
parity_done  input  1  register stage has captured parity byte
low_pkt_valid  input  1  register stage saw pkt_valid fall while stalled
detect_add  output  1  high in DECODE_ADDRESS
lfd_state  output  1  high in LOAD_FIRST_DATA (header write)
ld_state  output  1  high in LOAD_DATA
laf_state  output  1  high in LOAD_AFTER_FULL
full_state  output  1  high in FIFO_FULL_STATE
write_enb_reg  output  1  FIFO write enable request
rst_int_reg  output  1  clear internal parity registers (CHECK_PARITY_ERROR)
busy  output  1  stall source; source must hold data_in while high

Behaviour:
- States: DA (decode address), LFD, LD, FFS (fifo full), LAF, LP (load parity), CPE (check parity error), WTE (wait till empty).
- Reset (resetn=0, asynchronous): state=DA, addr_q=0. Outputs at reset: detect_add=1, all others 0.
- addr_q is loaded from data_in in DA when pkt_valid=1 and data_in!=2'b11. It holds otherwise.
- Transitions, evaluated each rising edge:
  - DA: pkt_valid & data_in!=3 & fifo_empty[data_in] -> LFD. pkt_valid & data_in!=3 & !fifo_empty[data_in] -> WTE. Otherwise stay. An invalid address 3 is never accepted.
  - LFD -> LD, unconditional.
  - LD: fifo_full -> FFS. Else if !pkt_valid -> LP. Else stay. fifo_full has priority over !pkt_valid.
  - FFS: !fifo_full -> LAF. Else stay.
  - LAF: parity_done -> DA. Else if low_pkt_valid -> LP. Else -> LD.
  - LP -> CPE, unconditional.
  - CPE: fifo_full -> FFS. Else -> DA.
  - WTE: fifo_empty[addr_q] -> LFD. Else stay.
- Soft reset: if soft_reset[addr_q]=1 in any state other than DA, the next state is DA. This overrides every transition above. soft_reset bits for non-selected destinations are ignored. In DA, soft_reset is ignored.
- Outputs are Moore, decoded from the current state only:
  - write_enb_reg = LD | LP | LAF
  - busy = LFD | FFS | LAF | LP | CPE | WTE (busy=0 in DA and LD)
  - rst_int_reg = CPE
  - Each *_state output is one-hot with its state.
- Latency: header accepted in DA at edge N, so lfd_state=1 in cycle N+1. The first payload is written in LD from cycle N+2. The parity byte is written in LP one cycle after pkt_valid falls in LD. The minimum packet has 1 header, P payload and 1 parity byte; DA is reached 3 cycles after pkt_valid falls (LP, CPE, DA).
- fifo_full rising in LFD has no effect; it is first examined in LD.
- No reachable illegal state. The default branch returns to DA.

Test Plan:
- Reset mid-LD: assert resetn=0 asynchronously between edges. State goes to DA immediately; detect_add=1, busy=0, write_enb_reg=0 with no clock edge.
- Normal packet, addr 1, fifo_empty=3'b111, 14 payload bytes, pkt_valid falls after byte 15. Required sequence: DA->LFD->LD(x14)->LP->CPE->DA. write_enb_reg high for 15 cycles total. rst_int_reg high for exactly 1 cycle.
- Busy destination, header addr 2 with fifo_empty=3'b011. Go to WTE with busy=1. When fifo_empty[2] rises, LFD follows on the next edge. Toggling fifo_empty[0] while in WTE causes no exit.
- FIFO full, addr 0: fifo_full=1 in the 5th LD cycle -> FFS, write_enb_reg=0, busy=1. fifo_full=0 -> LAF. With pkt_valid=1, low_pkt_valid=0, parity_done=0 -> back to LD. A second case sets low_pkt_valid=1 in LAF -> LP.
- Soft reset, addr 1 in LD: soft_reset=3'b010 -> DA next edge. soft_reset=3'b100 in the same state causes no change.
- Invalid address: pkt_valid=1, data_in=2'b11 for 3 cycles -> remains in DA, busy=0, addr_q unchanged.
